instr_mem_ldr: RTL and testbench

//  Parametrised, runtime-loadable instruction memory for the fetch stage.

---
 rtl/instr_mem_ldr.sv | 124 ++++++++++++
 tb/tb_instr_mem_ldr.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_ldr.sv
// instr_mem_ldr
//   Runtime-loadable instruction memory for the fetch stage. Fetches are a
//   registered read (latency 1) with a stall hold. A sequential load port
//   streams words into consecutive addresses starting at 0.
// Ports
//   Clk, Reset            : clock, synchronous active-high reset
//   PrgCtr, FetchReq      : fetch address and request
//   Stall                 : hold InstOut/InstValid
//   InstOut, InstValid    : registered fetch result and its valid flag
//   LdStart, LdWe, LdData : start/restart load, write strobe, write data
//   LdEnd                 : finish load
//   LdBusy, LdDone        : in-load flag, one-cycle exit pulse
//   LdCount               : words written by the current or last load
module instr_mem_ldr #(
  parameter int unsigned DW        = 9,
  parameter int unsigned AW        = 12,
  parameter string       INIT_FILE = ""
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [AW-1:0] PrgCtr,
  input  logic          FetchReq,
  input  logic          Stall,
  output logic [DW-1:0] InstOut,
  output logic          InstValid,
  input  logic          LdStart,
  input  logic          LdWe,
  input  logic [DW-1:0] LdData,
  input  logic          LdEnd,
  output logic          LdBusy,
  output logic          LdDone,
  output logic [AW:0]   LdCount
);

  typedef enum logic {ST_IDLE, ST_LOAD} state_t;

  logic [DW-1:0] r_mem [0:(2**AW)-1];

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_ptr,   w_ptr_nxt;
  logic [AW:0]   r_cnt,   w_cnt_nxt;
  logic          r_done,  w_done_nxt;
  logic          r_valid, w_valid_nxt;
  logic [DW-1:0] r_inst;
  logic          w_fetch;
  logic          w_wr;

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_valid_nxt = r_valid;
    w_fetch     = 1'b0;
    w_wr        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (LdStart) begin
          // load entry wins over a same-cycle fetch, which is dropped
          w_state_nxt = ST_LOAD;
          w_ptr_nxt   = '0;
          w_cnt_nxt   = '0;
          w_valid_nxt = 1'b0;
        end else if (!Stall) begin
          w_valid_nxt = FetchReq;
          w_fetch     = FetchReq;
        end
      end
      ST_LOAD: begin
        w_valid_nxt = 1'b0;
        if (LdStart) begin
          // restart beats LdEnd and LdWe: no write this cycle
          w_ptr_nxt = '0;
          w_cnt_nxt = '0;
        end else begin
          if (LdWe) begin
            w_wr      = 1'b1;
            w_cnt_nxt = r_cnt + (AW+1)'(1);
            if (r_ptr != '1) w_ptr_nxt = r_ptr + AW'(1);
          end
          // writing the last address ends the load; pointer parks there
          if (LdEnd || (LdWe && (r_ptr == '1))) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_inst  <= '0;
    end else begin
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_valid <= w_valid_nxt;
      if (w_fetch) r_inst <= r_mem[PrgCtr];
    end
  end

  // Memory has no reset; a write coinciding with Reset is suppressed.
  always_ff @(posedge Clk) begin
    if (w_wr && !Reset) r_mem[r_ptr] <= LdData;
  end

  assign InstOut   = r_inst;
  assign InstValid = r_valid;
  assign LdBusy    = (r_state == ST_LOAD);
  assign LdDone    = r_done;
  assign LdCount   = r_cnt;

endmodule

// File: tb/tb_instr_mem_ldr.sv
// tb_instr_mem_ldr
//   Randomized bench for instr_mem_ldr (DW=9, AW=4). Expected values come
//   from a word-array image of memory plus the load word count and the last
//   fetch result, updated from the behavioural rules of the block.
module tb_instr_mem_ldr;

  localparam int DW    = 9;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [AW-1:0] PrgCtr;
  logic          FetchReq, Stall;
  logic [DW-1:0] InstOut;
  logic          InstValid;
  logic          LdStart, LdWe, LdEnd;
  logic [DW-1:0] LdData;
  logic          LdBusy, LdDone;
  logic [AW:0]   LdCount;

  instr_mem_ldr #(.DW(DW), .AW(AW), .INIT_FILE("")) dut (
    .Clk(Clk), .Reset(Reset), .PrgCtr(PrgCtr), .FetchReq(FetchReq),
    .Stall(Stall), .InstOut(InstOut), .InstValid(InstValid),
    .LdStart(LdStart), .LdWe(LdWe), .LdData(LdData), .LdEnd(LdEnd),
    .LdBusy(LdBusy), .LdDone(LdDone), .LdCount(LdCount)
  );

  always #5 Clk = ~Clk;

  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;
  logic [DW-1:0] mem_m [DEPTH];
  int            words;      // words written by the current/last load
  logic [DW-1:0] exp_inst;
  logic          exp_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic quiet();
    FetchReq = 1'b0; Stall = 1'b0; LdStart = 1'b0; LdWe = 1'b0; LdEnd = 1'b0;
  endtask

  // One IDLE cycle on the fetch path.
  task automatic fetch(input int addr, input logic req, input logic stall, input string tag);
    quiet();
    PrgCtr = AW'(addr); FetchReq = req; Stall = stall;
    tick();
    if (!stall) begin
      exp_valid = req;
      if (req) exp_inst = mem_m[addr];
    end
    check({tag, ".valid"}, 32'(InstValid), 32'(exp_valid));
    check({tag, ".inst"},  32'(InstOut),   32'(exp_inst));
    check({tag, ".done"},  32'(LdDone),    32'd0);
    quiet();
  endtask

  task automatic ld_start(input logic with_fetch);
    quiet();
    LdStart = 1'b1; FetchReq = with_fetch; PrgCtr = AW'($urandom_range(0, DEPTH-1));
    tick();
    words = 0; exp_valid = 1'b0;
    check("start.busy",  32'(LdBusy),    32'd1);
    check("start.cnt",   32'(LdCount),   32'd0);
    check("start.valid", 32'(InstValid), 32'd0);
    quiet();
  endtask

  task automatic ld_word(input logic [DW-1:0] d, input logic fin);
    logic ends;
    quiet();
    LdWe = 1'b1; LdData = d; LdEnd = fin;
    FetchReq = 1'($urandom); Stall = 1'($urandom);
    tick();
    mem_m[words] = d;
    words++;
    ends = fin || (words == DEPTH);
    check("wr.cnt",   32'(LdCount),   32'(words));
    check("wr.busy",  32'(LdBusy),    32'(!ends));
    check("wr.done",  32'(LdDone),    32'(ends));
    check("wr.valid", 32'(InstValid), 32'd0);
    quiet();
  endtask

  task automatic ld_end();
    quiet();
    LdEnd = 1'b1;
    tick();
    check("end.done", 32'(LdDone),  32'd1);
    check("end.busy", 32'(LdBusy),  32'd0);
    check("end.cnt",  32'(LdCount), 32'(words));
    quiet();
  endtask

  initial begin
    logic [DW-1:0] a, b;
    int len;
    logic fin;
    quiet(); PrgCtr = '0; LdData = '0; Reset = 1'b1;
    exp_inst = '0; exp_valid = 1'b0; words = 0;
    tick(); tick();
    check("rst.valid", 32'(InstValid), 32'd0);
    check("rst.inst",  32'(InstOut),   32'd0);
    check("rst.busy",  32'(LdBusy),    32'd0);
    check("rst.done",  32'(LdDone),    32'd0);
    check("rst.cnt",   32'(LdCount),   32'd0);
    Reset = 1'b0;

    // Short load with fixed words, then fetch the cycle after LdDone.
    ld_start(1'b0);
    ld_word(9'h0AA, 1'b0); ld_word(9'h155, 1'b0); ld_word(9'h1FF, 1'b0);
    ld_end();
    fetch(0, 1'b1, 1'b0, "rd0"); fetch(1, 1'b1, 1'b0, "rd1"); fetch(2, 1'b1, 1'b0, "rd2");
    fetch(0, 1'b0, 1'b0, "idle");

    // Full load without LdEnd auto-exits after the last address.
    ld_start(1'b0);
    for (int i = 0; i < DEPTH; i++) ld_word(DW'($urandom), 1'b0);
    check("full.cnt", 32'(LdCount), 32'(DEPTH));
    tick();
    check("full.done_pulse", 32'(LdDone), 32'd0);
    LdWe = 1'b1; LdData = ~mem_m[0]; tick();    // LdWe in IDLE: no write
    LdData = ~mem_m[DEPTH-1]; tick(); quiet();
    check("idlewe.cnt",  32'(LdCount), 32'(DEPTH));
    check("idlewe.busy", 32'(LdBusy),  32'd0);
    fetch(0, 1'b1, 1'b0, "idlewe.a0");
    fetch(DEPTH-1, 1'b1, 1'b0, "idlewe.a15");
    for (int i = 0; i < DEPTH; i++) fetch($urandom_range(0, DEPTH-1), 1'b1, 1'b0, "b2b");

    // Stall hold while PrgCtr moves, then release with no request.
    fetch(2, 1'b1, 1'b0, "st.issue");
    for (int i = 0; i < 3; i++) fetch($urandom_range(0, DEPTH-1), 1'b1, 1'b1, "st.hold");
    fetch($urandom_range(0, DEPTH-1), 1'b0, 1'b0, "st.release");

    // LdStart with FetchReq; LdWe with LdEnd.
    ld_start(1'b1);
    ld_word(DW'($urandom), 1'b1);
    fetch(0, 1'b1, 1'b0, "we_end.rd");

    // Restart with LdWe mid-load: no write, count back to 0.
    a = DW'($urandom); b = DW'($urandom);
    ld_start(1'b0);
    ld_word(a, 1'b0); ld_word(b, 1'b0);
    LdStart = 1'b1; LdWe = 1'b1; LdData = ~a; tick(); quiet();
    words = 0;
    check("restart.cnt",  32'(LdCount), 32'd0);
    check("restart.busy", 32'(LdBusy),  32'd1);
    check("restart.done", 32'(LdDone),  32'd0);
    ld_end();
    fetch(0, 1'b1, 1'b0, "restart.a0");
    fetch(1, 1'b1, 1'b0, "restart.a1");

    // Reset mid-load after two writes.
    ld_start(1'b0);
    ld_word(DW'($urandom), 1'b0); ld_word(DW'($urandom), 1'b0);
    Reset = 1'b1; LdWe = 1'b1; LdData = DW'($urandom); tick(); quiet(); Reset = 1'b0;
    words = 0; exp_inst = '0; exp_valid = 1'b0;
    check("rstld.busy", 32'(LdBusy),  32'd0);
    check("rstld.cnt",  32'(LdCount), 32'd0);
    check("rstld.done", 32'(LdDone),  32'd0);
    check("rstld.inst", 32'(InstOut), 32'd0);
    tick();
    check("rstld.nodone", 32'(LdDone), 32'd0);
    fetch(0, 1'b1, 1'b0, "rstld.a0"); fetch(1, 1'b1, 1'b0, "rstld.a1");
    fetch(2, 1'b1, 1'b0, "rstld.a2");

    // Random loads of random length followed by random fetch traffic.
    repeat (6) begin
      len = $urandom_range(1, DEPTH);
      ld_start(1'($urandom));
      for (int i = 0; i < len; i++) begin
        fin = (i == len-1) && (len < DEPTH) && 1'($urandom);
        ld_word(DW'($urandom), fin);
        if (i == len-1 && !fin && len < DEPTH) ld_end();
      end
      repeat (12) fetch($urandom_range(0, DEPTH-1), 1'($urandom), ($urandom_range(0, 3) == 0), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
